// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for a core load/store port. One request is accepted per handshake
//   while idle; after WAIT_CYCLES wait states the access executes on a little-endian word
//   array and a single-cycle response strobe is returned.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   : misaligned H/W accesses and funct3 in {011,110,111} return rsp_err = 1,
//               rsp_rdata = 0, and never write the array.
//   undefined : addresses are aligned down to the access size, illegal funct3 acts as a
//               word access, rsp_err is always 0.
//
// Ports
//   clk        global clock
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (idle)
//   req_we     store request
//   req_re     load request
//   req_addr   byte address
//   req_wdata  store data, right-aligned
//   req_funct3 access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  extended load data (0 for stores and errors)
//   rsp_err    access error
//   busy       request in flight
module dmem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DM_ADDRESS  = 9,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_re,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned DEPTH    = 2 ** (DM_ADDRESS - 2);
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic capture;
    logic exec;

    logic [31:0] mem [DEPTH];

    // ---------------------------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    // A handshake with neither we nor re is consumed silently.
                    if (req_we || req_re) begin
                        if (NO_WAIT) begin
                            state_d = ST_RESP;
                            exec    = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Execution operands: with zero wait states the access runs on the accept edge, so the
    // live request is used; otherwise the latched copy is used.
    // ---------------------------------------------------------------------------------------
    logic                  sel_live;
    logic [DM_ADDRESS-1:0] x_addr;
    logic [DATA_W-1:0]     x_wdata;
    logic [2:0]            x_funct3;
    logic                  x_we;
    logic [DM_ADDRESS-3:0] x_idx;
    logic [1:0]            x_lane;
    logic                  x_err;

    assign sel_live = (state_q == ST_IDLE);
    assign x_addr   = sel_live ? req_addr   : addr_q;
    assign x_wdata  = sel_live ? req_wdata  : wdata_q;
    assign x_funct3 = sel_live ? req_funct3 : funct3_q;
    assign x_we     = sel_live ? req_we     : we_q;
    assign x_idx    = x_addr[DM_ADDRESS-1:2];
    assign x_lane   = x_addr[1:0];

`ifdef DMEM_ERR_EN
    logic x_misaligned;
    logic x_illegal;

    always_comb begin
        x_misaligned = 1'b0;
        case (x_funct3[1:0])
            2'b01:   x_misaligned = x_lane[0];
            2'b10:   x_misaligned = (x_lane != 2'b00);
            default: x_misaligned = 1'b0;
        endcase
    end

    assign x_illegal = (x_funct3 == 3'b011) || (x_funct3 == 3'b110) || (x_funct3 == 3'b111);
    assign x_err     = x_misaligned || x_illegal;
`else
    assign x_err = 1'b0;
`endif

    // ---------------------------------------------------------------------------------------
    // Store path: byte enables and lane-replicated write data
    // ---------------------------------------------------------------------------------------
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        mem_we;

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = x_wdata;
        case (x_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << x_lane;
                wr_data = {4{x_wdata[7:0]}};
            end
            2'b01: begin
                // Half lane chosen by addr[1] only, which aligns odd addresses down.
                wr_be   = x_lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{x_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = x_wdata;
            end
        endcase
    end

    // reset gating only matters for the zero-wait build, where exec comes straight from IDLE.
    assign mem_we = exec && x_we && !x_err && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[x_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Load path: lane select and extension
    // ---------------------------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_data;

    assign rd_word = mem[x_idx];
    assign rd_half = x_lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (x_lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        ld_data = rd_word;
        case (x_funct3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Request latch and response registers (response fields hold until the next access)
    // ---------------------------------------------------------------------------------------
    always_comb begin
        addr_d   = capture ? req_addr   : addr_q;
        wdata_d  = capture ? req_wdata  : wdata_q;
        funct3_d = capture ? req_funct3 : funct3_q;
        we_d     = capture ? req_we     : we_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (exec) begin
            rdata_d = (x_we || x_err) ? '0 : ld_data;
            err_d   = x_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_we, req_re;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        v2, ready2, rv2, err2, busy2;
    logic [31:0] rd2;
    logic        v0, ready0, rv0, err0, busy0;
    logic [31:0] rd0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (v2),
        .req_ready  (ready2),
        .req_we     (req_we),
        .req_re     (req_re),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rv2),
        .rsp_rdata  (rd2),
        .rsp_err    (err2),
        .busy       (busy2)
    );

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (v0),
        .req_ready  (ready0),
        .req_we     (req_we),
        .req_re     (req_re),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rv0),
        .rsp_rdata  (rd0),
        .rsp_err    (err0),
        .busy       (busy0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request to the selected instance (sel=2 or 0) and wait, bounded, for its
    // response. lat counts negedges after the accept edge (1 = cycle T+1); it stays 0 when
    // no response arrives within the bound.
    task automatic do_req(input int sel, input logic we, input logic re, input logic [8:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_we = we; req_re = re; req_addr = a; req_wdata = wd; req_funct3 = f3;
        if (sel == 2) v2 = 1'b1; else v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0; v0 = 1'b0;
        lat = 0; rd = 32'd0; er = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if ((sel == 2) ? rv2 : rv0) begin
                lat = i;
                rd  = (sel == 2) ? rd2 : rd0;
                er  = (sel == 2) ? err2 : err0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ld(input int sel, input string tag, input logic [8:0] a, input logic [2:0] f3,
                      input logic [31:0] exp, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(sel, 1'b0, 1'b1, a, 32'd0, f3, rd, er, lat);
        check_eq(tag, rd, exp);
        check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_eq({tag, "_lat"}, lat, (sel == 2) ? 32'd3 : 32'd1);
    endtask

    task automatic st(input int sel, input string tag, input logic [8:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(sel, 1'b1, 1'b0, a, wd, f3, rd, er, lat);
        check_eq(tag, rd, 32'd0);
        check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_eq({tag, "_lat"}, lat, (sel == 2) ? 32'd3 : 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1; v2 = 1'b0; v0 = 1'b0;
        req_we = 1'b0; req_re = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = 3'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'd0, ready2}, 32'd1);
        check_eq("rst_valid", {31'd0, rv2}, 32'd0);
        check_eq("rst_rdata", rd2, 32'd0);
        check_eq("rst_err", {31'd0, err2}, 32'd0);
        check_eq("rst_busy", {31'd0, busy2}, 32'd0);
        check_eq("rst_ready0", {31'd0, ready0}, 32'd1);
        reset = 1'b0;

        // Test 1: SW with exact cycle-by-cycle timing
        @(negedge clk);
        req_we = 1'b1; req_re = 1'b0; req_addr = 9'h010; req_wdata = 32'hDEADBEEF;
        req_funct3 = 3'b010; v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("t1_valid_c%0d", c), {31'd0, rv2}, (c == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("t1_busy_c%0d", c), {31'd0, busy2}, (c <= 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("t1_ready_c%0d", c), {31'd0, ready2}, (c == 4) ? 32'd1 : 32'd0);
            if (c == 3) check_eq("t1_sw_rdata", rd2, 32'd0);
            @(negedge clk);
        end
        ld(2, "t1_lw", 9'h010, 3'b010, 32'hDEADBEEF, 1'b0);

        // Test 2: byte store / loads
        st(2, "t2_sb", 9'h013, 32'h000000A5, 3'b000, 1'b0);
        ld(2, "t2_lb", 9'h013, 3'b000, 32'hFFFFFFA5, 1'b0);
        ld(2, "t2_lbu", 9'h013, 3'b100, 32'h000000A5, 1'b0);
        ld(2, "t2_lw", 9'h010, 3'b010, 32'hA5ADBEEF, 1'b0);

        // Test 3: half store / loads
        st(2, "t3_sh", 9'h012, 32'h00008001, 3'b001, 1'b0);
        ld(2, "t3_lh", 9'h012, 3'b001, 32'hFFFF8001, 1'b0);
        ld(2, "t3_lhu", 9'h012, 3'b101, 32'h00008001, 1'b0);
        ld(2, "t3_lw", 9'h010, 3'b010, 32'h8001BEEF, 1'b0);

        // Test 4: misaligned word accesses
`ifdef DMEM_ERR_EN
        ld(2, "t4_lw_mis", 9'h011, 3'b010, 32'd0, 1'b1);
        st(2, "t4_sw_mis", 9'h011, 32'h11111111, 3'b010, 1'b1);
        ld(2, "t4_lw_after", 9'h010, 3'b010, 32'h8001BEEF, 1'b0);
        ld(2, "t4_illegal", 9'h010, 3'b011, 32'd0, 1'b1);
`else
        ld(2, "t4_lw_mis", 9'h011, 3'b010, 32'h8001BEEF, 1'b0);
        st(2, "t4_sw_mis", 9'h011, 32'h11111111, 3'b010, 1'b0);
        ld(2, "t4_lw_after", 9'h010, 3'b010, 32'h11111111, 1'b0);
        ld(2, "t4_illegal", 9'h010, 3'b011, 32'h11111111, 1'b0);
`endif

        // Test 5: reset during WAIT aborts the store
        st(2, "t5_pre", 9'h020, 32'hCAFEF00D, 3'b010, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_re = 1'b0; req_addr = 9'h020; req_wdata = 32'h12345678;
        req_funct3 = 3'b010; v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        check_eq("t5_busy_pre", {31'd0, busy2}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t5_ready_rst", {31'd0, ready2}, 32'd1);
        check_eq("t5_busy_rst", {31'd0, busy2}, 32'd0);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rv2) seen++;
        end
        check_eq("t5_no_rsp", seen, 32'd0);
        ld(2, "t5_lw", 9'h020, 3'b010, 32'hCAFEF00D, 1'b0);

        // Test 6: zero wait states, back-to-back loads and a no-op handshake
        st(0, "t6_sw40", 9'h040, 32'h0BADF00D, 3'b010, 1'b0);
        st(0, "t6_sw44", 9'h044, 32'h00C0FFEE, 3'b010, 1'b0);
        @(negedge clk);
        req_we = 1'b0; req_re = 1'b1; req_addr = 9'h040; req_funct3 = 3'b010; v0 = 1'b1;
        check_eq("t6_ready_T", {31'd0, ready0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_valid_T1", {31'd0, rv0}, 32'd1);
        check_eq("t6_rdata_T1", rd0, 32'h0BADF00D);
        check_eq("t6_ready_T1", {31'd0, ready0}, 32'd0);
        req_addr = 9'h044;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_valid_T2", {31'd0, rv0}, 32'd0);
        check_eq("t6_ready_T2", {31'd0, ready0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        check_eq("t6_valid_T3", {31'd0, rv0}, 32'd1);
        check_eq("t6_rdata_T3", rd0, 32'h00C0FFEE);
        @(negedge clk);
        req_we = 1'b0; req_re = 1'b0; v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        check_eq("t6_noop_valid", {31'd0, rv0}, 32'd0);
        check_eq("t6_noop_ready", {31'd0, ready0}, 32'd1);
        check_eq("t6_noop_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        check_eq("t6_noop_valid2", {31'd0, rv0}, 32'd0);
        check_eq("t6_rdata_hold", rd0, 32'h00C0FFEE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store interface.
- Accepts one load or store per handshake and performs byte, half and word accesses selected by funct3 on a little-endian word array.
- Returns a one-cycle response after a programmable number of wait states, so the core can be exercised against non-zero-latency data memory.

Parameters:
DATA_W, 32, data width (fixed 32 for byte-lane logic)
DM_ADDRESS, 9, byte-address width; array holds 2**(DM_ADDRESS-2) words
WAIT_CYCLES, 1, wait states between accept and response, legal 0..15

Ports:
clk  input  1  global clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  store request (MemWrite)
req_re  input  1  load request (MemRead)
req_addr  input  DM_ADDRESS  byte address
req_wdata  input  DATA_W  store data, right-aligned
req_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  DATA_W  extended load data
rsp_err  output  1  misaligned or illegal access (see Optional Feature)
busy  output  1  request in flight

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; busy = 0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Handshake = req_valid & req_ready at a rising edge; addr, wdata, funct3 and we are latched.
  - If req_we | req_re: go to WAIT, with counter = WAIT_CYCLES-1. If WAIT_CYCLES = 0, go directly to RESP.
  - If req_we = req_re = 0: handshake completes, no response is produced, state stays IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At the edge where the counter = 0, the access executes and state moves to RESP.
- RESP:
  - rsp_valid = 1 for exactly this cycle; there is no response backpressure.
  - Next state is IDLE.
- Timing:
  - Request accepted at edge T → rsp_valid high in cycle T+1+WAIT_CYCLES.
  - req_ready = 1 only in IDLE; throughput is one request per WAIT_CYCLES+2 cycles.
- Access execution:
  - Store commits on the edge entering RESP, using byte enables from funct3[1:0] and addr[1:0]. SB writes lane addr[1:0]; SH writes lanes addr[1]*2+{0,1}; SW writes all lanes. funct3[2] is ignored for stores.
  - Load reads the word at addr[DM_ADDRESS-1:2], selects the lane, then sign-extends (B, H) or zero-extends (BU, HU, W).
  - For a store, rsp_rdata = 0.
  - If we = re = 1, the request is treated as a store.
- rsp_rdata and rsp_err hold their value until the next RESP.
- busy = (state != IDLE).
- Reset mid-operation: state forced to IDLE and no response is issued. A store still in WAIT is aborted and never committed.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined:
  - Misaligned accesses (H with addr[0] = 1; W with addr[1:0] != 0) and funct3 in {011, 110, 111} are errors.
  - On an error, rsp_valid is issued with normal timing, rsp_err = 1, rsp_rdata = 0, and no array write occurs.
- Undefined:
  - Addresses are aligned down to the access size.
  - Illegal funct3 is treated as a word access.
  - rsp_err is tied to 0.

Test Plan:
1. WAIT_CYCLES=2: SW 0x010 ← 0xDEADBEEF accepted at edge 0 → rsp_valid only in cycle 3, rdata 0, busy high cycles 1-3. Then LW 0x010 → rsp_rdata 0xDEADBEEF.
2. After test 1:
   - SB 0x013 ← 0x000000A5.
   - LB 0x013 → 0xFFFFFFA5; LBU 0x013 → 0x000000A5; LW 0x010 → 0xA5ADBEEF.
3. SH 0x012 ← 0x00008001 → LH 0x012 = 0xFFFF8001; LHU 0x012 = 0x00008001; LW 0x010 = 0x8001BEEF.
4. LW 0x011 and SW 0x011 ← 0x11111111:
   - With DMEM_ERR_EN: rsp_err = 1, rdata 0; a following LW 0x010 is unchanged.
   - Without DMEM_ERR_EN: LW returns the word at 0x010, and the SW overwrites 0x010.
5. SW 0x020 ← 0x12345678, then pulse reset during WAIT → no rsp_valid; req_ready = 1 immediately. A subsequent LW 0x020 returns the prior contents.
6. WAIT_CYCLES=0: back-to-back LW requests → rsp_valid at T+1, next accept at T+2. A request with we = re = 0 → no rsp_valid and req_ready stays 1.
